filter_sched: RTL and testbench

- Time-shares one moving-average `filter` instance (2**M-sample window, no backpressure) between NUM_REQ requesters.
- Grants ownership per burst using round-robin arbitration.
- On a change of owner, flushes the filter history by driving 2**M zero samples.
- Suppresses warm-up averages, then routes each filter average back with the owner's ID. Sits between the sample sources and the filter instance.

---
 rtl/filter_sched.sv | 185 ++++++++++++++++++
 tb/tb_filter_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sched.sv
// filter_sched: time-shares one moving-average filter between NUM_REQ
// requesters. Ownership is granted per burst (round-robin), the filter
// history is flushed with zero samples on a change of owner, warm-up
// averages of a freshly flushed burst are suppressed, and every forwarded
// average is tagged with the ID of the owner that produced it.
module filter_sched #(
  parameter int NUM_REQ         = 4,
  parameter int M               = 2,
  parameter int N               = 16,
  parameter int SUPPRESS_WARMUP = 1,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_sample,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [N-1:0]         f_sample,
  output logic                 f_sample_valid,
  input  logic [N-1:0]         f_average,
  input  logic                 f_average_valid,
  output logic [N-1:0]         out_average,
  output logic                 out_valid,
  output logic [IW-1:0]        out_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int WIN = 1 << M;
  // Last value of a 0-based count over one filter window.
  localparam logic [M-1:0] CNT_MAX = M'(WIN - 1);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);
  localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;
  logic [IW-1:0] rr_ptr;
  logic          hist_clean;
  logic [M-1:0]  flush_cnt;
  logic [M-1:0]  warm_cnt;
  logic          warm_done;
  logic          fwd_q;
  logic [IW-1:0] id_q;

  logic [N-1:0]  samples [NUM_REQ];
  logic          any_req;
  logic          found;
  logic [IW-1:0] winner;
  logic [IW:0]   cand_w;
  logic [IW-1:0] cand;
  logic          accept;
  logic          warm_hit;

  // Unpack the flat sample bus so the owner's sample can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      samples[i] = req_sample[i*N +: N];
    end
  end

  // Round-robin search: first requesting index at or above rr_ptr, wrapping.
  always_comb begin
    any_req = |req_valid;
    found   = 1'b0;
    winner  = rr_ptr;
    cand_w  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_w = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand_w >= NUM_REQ_W) begin
        cand_w = cand_w - NUM_REQ_W;
      end
      cand = cand_w[IW-1:0];
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Filter-side muxing and ready generation follow the current state directly.
  always_comb begin
    req_ready      = '0;
    f_sample       = '0;
    f_sample_valid = 1'b0;
    case (state)
      FLUSH: begin
        f_sample_valid = 1'b1;
      end
      ACTIVE: begin
        req_ready[owner] = 1'b1;
        f_sample         = samples[owner];
        f_sample_valid   = req_valid[owner];
      end
      default: begin
      end
    endcase
  end

  assign accept   = (state == ACTIVE) && req_valid[owner];
  // The accept that completes a full window of real samples.
  assign warm_hit = accept && (warm_cnt == CNT_MAX);

  // Averages arrive one cycle after their sample, so the forward decision and
  // owner tag are registered alongside and stay valid across a handover.
  assign out_valid   = f_average_valid & fwd_q;
  assign out_average = f_average;
  assign out_id      = id_q;

  // Arbitration / flush / burst FSM plus the forwarding pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= '0;
      rr_ptr     <= '0;
      hist_clean <= 1'b1;
      flush_cnt  <= '0;
      warm_cnt   <= '0;
      warm_done  <= 1'b0;
      fwd_q      <= 1'b0;
      id_q       <= '0;
    end else begin
      fwd_q <= accept && (warm_done || warm_hit);
      id_q  <= owner;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            warm_cnt  <= '0;
            flush_cnt <= '0;
            if (hist_clean || (winner == last_owner)) begin
              state     <= ACTIVE;
              warm_done <= !(hist_clean && (SUPPRESS_WARMUP != 0));
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == CNT_MAX) begin
            state     <= ACTIVE;
            warm_cnt  <= '0;
            warm_done <= (SUPPRESS_WARMUP == 0);
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (warm_cnt != CNT_MAX) begin
              warm_cnt <= warm_cnt + 1'b1;
            end
            if (warm_hit) begin
              warm_done <= 1'b1;
            end
            if (req_last[owner]) begin
              state      <= IDLE;
              last_owner <= owner;
              rr_ptr     <= (owner == LAST_ID) ? '0 : owner + 1'b1;
              hist_clean <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A pending forward must always be matched by an average from the filter.
  fwd_matches_filter: assert property (@(posedge clk) disable iff (rst)
    fwd_q |-> f_average_valid)
    else $error("filter_sched: forward pending without f_average_valid");
`endif

endmodule

// File: tb/tb_filter_sched.sv
// tb_filter_sched: directed bench for filter_sched with a behavioural
// moving-average filter, an expected-average scoreboard and a monitor.
module tb_filter_sched;

  localparam int NUM_REQ = 4;
  localparam int M       = 2;
  localparam int N       = 16;
  localparam int IW      = 2;
  localparam int WIN     = 1 << M;

  typedef struct {
    int avg;
    int id;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_sample;
  logic [NUM_REQ-1:0]   req_last;
  logic [N-1:0]         f_sample;
  logic                 f_sample_valid;
  logic [N-1:0]         f_average;
  logic                 f_average_valid;
  logic [N-1:0]         out_average;
  logic                 out_valid;
  logic [IW-1:0]        out_id;

  int   checks = 0;
  int   errors = 0;
  int   flush_cycles = 0;
  exp_t exp_q[$];
  int   grant_q[$];

  logic [N-1:0] fhist [WIN-1];

  filter_sched #(
    .NUM_REQ(NUM_REQ),
    .M(M),
    .N(N),
    .SUPPRESS_WARMUP(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sample(req_sample),
    .req_last(req_last),
    .f_sample(f_sample),
    .f_sample_valid(f_sample_valid),
    .f_average(f_average),
    .f_average_valid(f_average_valid),
    .out_average(out_average),
    .out_valid(out_valid),
    .out_id(out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window average including the incoming sample and the previous WIN-1.
  function automatic logic [N-1:0] filter_avg(input logic [N-1:0] s);
    logic [N+M-1:0] acc;
    acc = (N+M)'(s);
    for (int i = 0; i < WIN-1; i++) acc = acc + (N+M)'(fhist[i]);
    return N'(acc >> M);
  endfunction

  // Behavioural filter: one-cycle latency, history zeroed by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN-1; i++) fhist[i] <= '0;
      f_average       <= '0;
      f_average_valid <= 1'b0;
    end else begin
      f_average_valid <= f_sample_valid;
      if (f_sample_valid) begin
        f_average <= filter_avg(f_sample);
        fhist[0]  <= f_sample;
        for (int i = 1; i < WIN-1; i++) fhist[i] <= fhist[i-1];
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: scoreboard pops, flush-cycle counting and grant logging.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out actual avg=%0d id=%0d expected no output",
                   out_average, out_id);
        end else begin
          e = exp_q.pop_front();
          check_output("out_average", int'(out_average), e.avg);
          check_output("out_id", int'(out_id), e.id);
        end
      end
      if (f_sample_valid && (req_ready == '0)) begin
        flush_cycles++;
        check_output("flush_sample", int'(f_sample), 0);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
      end
    end
  end

  task automatic expect_avg(input int avg, input int id);
    exp_t e;
    e.avg = avg;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  // Present one sample on requester id and hold it until it is accepted.
  task automatic apply_stimulus(input int id, input int value, input bit last);
    bit accepted;
    req_valid[id]          = 1'b1;
    req_sample[id*N +: N]  = N'(value);
    req_last[id]           = last;
    accepted = 1'b0;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (req_ready[id]) accepted = 1'b1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=no ready on req %0d expected ready", id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_req(input int id);
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check_output("pending_expected", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    req_sample = '0;
    #2;
    check_output("rst_req_ready", int'(req_ready), 0);
    check_output("rst_f_sample_valid", int'(f_sample_valid), 0);
    check_output("rst_f_sample", int'(f_sample), 0);
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_out_id", int'(out_id), 0);
    check_output("rst_out_average", int'(out_average), 0);
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    flush_cycles = 0;
    grant_q.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit found;
    rst        = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    req_sample = '0;

    // Single owner from reset: only the full-window average is forwarded.
    do_reset();
    expect_avg(10, 1);
    apply_stimulus(1, 4, 0);
    apply_stimulus(1, 8, 0);
    apply_stimulus(1, 12, 0);
    apply_stimulus(1, 16, 1);
    release_req(1);
    settle();
    check_output("t1_flush_cycles", flush_cycles, 0);

    // Handover with flush between requester 0 and requester 2.
    do_reset();
    expect_avg(100, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 100, i == 3);
    release_req(0);
    expect_avg(20, 2);
    for (int i = 0; i < 4; i++) apply_stimulus(2, 20, i == 3);
    release_req(2);
    settle();
    check_output("t2_flush_cycles", flush_cycles, 4);

    // Round-robin fairness with 1-sample bursts from every requester.
    do_reset();
    req_valid  = '1;
    req_last   = '1;
    req_sample = {16'd4, 16'd3, 16'd2, 16'd1};
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (grant_q.size() >= 5) found = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    req_last  = '0;
    check_output("t3_grant_count_reached", int'(found), 1);
    if (grant_q.size() >= 5) begin
      check_output("t3_grant0", grant_q[0], 0);
      check_output("t3_grant1", grant_q[1], 1);
      check_output("t3_grant2", grant_q[2], 2);
      check_output("t3_grant3", grant_q[3], 3);
      check_output("t3_grant4", grant_q[4], 0);
    end
    settle();

    // Same-owner re-grant keeps history and forwards immediately.
    do_reset();
    expect_avg(8, 3);
    for (int i = 0; i < 4; i++) apply_stimulus(3, 8, i == 3);
    release_req(3);
    expect_avg(16, 3);
    expect_avg(24, 3);
    apply_stimulus(3, 40, 0);
    apply_stimulus(3, 40, 1);
    release_req(3);
    settle();
    check_output("t4_flush_cycles", flush_cycles, 0);

    // Reset during the second flush cycle.
    do_reset();
    apply_stimulus(0, 5, 1);
    release_req(0);
    req_valid[1]         = 1'b1;
    req_sample[1*N +: N] = 16'd9;
    req_last[1]          = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (f_sample_valid && (req_ready == '0)) found = 1'b1;
    end
    check_output("t5_flush_seen", int'(found), 1);
    @(posedge clk);
    #1;
    check_output("t5_in_flush", int'(f_sample_valid), 1);
    rst = 1'b1;
    #1;
    check_output("t5_rst_req_ready", int'(req_ready), 0);
    check_output("t5_rst_f_sample_valid", int'(f_sample_valid), 0);
    check_output("t5_rst_out_valid", int'(out_valid), 0);
    release_req(1);
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    flush_cycles = 0;
    expect_avg(12, 1);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 12, i == 3);
    release_req(1);
    settle();
    check_output("t5_flush_after_reset", flush_cycles, 0);

    // Owner stall: grant stays on requester 2 while requester 0 waits.
    do_reset();
    expect_avg(40, 2);
    apply_stimulus(2, 40, 0);
    apply_stimulus(2, 40, 0);
    req_valid[2]         = 1'b0;
    req_valid[0]         = 1'b1;
    req_sample[0*N +: N] = 16'd7;
    req_last[0]          = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("t6_stall_ready", int'(req_ready), 4);
      check_output("t6_stall_fvalid", int'(f_sample_valid), 0);
    end
    @(posedge clk);
    #1;
    apply_stimulus(2, 40, 0);
    apply_stimulus(2, 40, 1);
    release_req(2);
    apply_stimulus(0, 7, 1);
    release_req(0);
    settle();
    check_output("t6_flush_cycles", flush_cycles, 4);
    check_output("final_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
